// File: rtl/serial_adder.sv
// Bit-serial adder: operands are added LSB-first, one bit per clock, through a
// full-adder cell built from two half adders and a carry flip-flop.
// valid/ready handshakes on both the operand and the result side.

// Single-bit half adder used twice per full-adder cell.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    // Sum and carry of two bits.
    assign s = x ^ y;
    assign c = x & y;

endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              c_out_q, c_out_d;
    logic              out_valid_q, out_valid_d;

    // Full-adder cell on the current operand LSBs and the stored carry.
    logic ha0_s, ha0_c, ha1_c;
    logic bit_s, bit_c;

    half_adder u_ha0 (
        .x (a_q[0]),
        .y (b_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha1 (
        .x (ha0_s),
        .y (carry_q),
        .s (bit_s),
        .c (ha1_c)
    );

    assign bit_c = ha0_c | ha1_c;

    // Next-state logic: operand load, per-bit shift and result handshake.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        c_out_d     = c_out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                acc_d   = {bit_s, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    // Result is published in one go so sum stays stable while shifting.
                    sum_d       = {bit_s, acc_q[WIDTH-1:1]};
                    c_out_d     = bit_c;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed corner cases plus randomized traffic with
// result stalls, checked against a queue of a+b+c_in sums.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       c_out;
    logic       busy;

    logic       ready_ctl;
    logic       rnd_ready;
    logic       rand_mode;
    logic       mon_en;

    int n_checks;
    int n_errors;
    int n_acc;
    int n_got;
    logic [8:0] exp_q[$];

    serial_adder #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    assign out_ready = rand_mode ? rnd_ready : ready_ctl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready <= ($urandom_range(0, 3) != 0);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: every accepted operand set queues its true sum; results pop in order.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(9'(a) + 9'(b) + 9'(c_in));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("rand_extra", {23'd0, c_out, sum}, 32'h1ff_ffff);
                end else begin
                    check_val("rand_sum", {23'd0, c_out, sum}, {23'd0, exp_q.pop_front()});
                end
                n_got++;
            end
        end
    end

    // Presents operands, waits for acceptance, scrambles the inputs, then counts
    // rising edges until out_valid is seen.
    task automatic start_add(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                             output int lat, output bit ok);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = oa;
        b        = ob;
        c_in     = oc;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~oa;
        b        = ~ob;
        c_in     = ~oc;
        lat = 0;
        ok  = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_add(input string tag, input logic [7:0] oa, input logic [7:0] ob,
                           input logic oc, input logic [7:0] es, input logic ec);
        int lat;
        bit ok;
        ready_ctl = 1'b1;
        start_add(oa, ob, oc, lat, ok);
        check_val({tag, "_lat"}, lat, 32'd8);
        check_val({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        check_val({tag, "_cout"}, {31'd0, c_out}, {31'd0, ec});
        @(negedge clk);
        check_val({tag, "_done1"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        bit ok;
        bit seen;
        n_checks  = 0;
        n_errors  = 0;
        n_acc     = 0;
        n_got     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        c_in      = 1'b0;
        ready_ctl = 1'b1;
        rnd_ready = 1'b1;
        rand_mode = 1'b0;
        mon_en    = 1'b0;

        #3;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_sum", {24'd0, sum}, 32'd0);
        check_val("rst_cout", {31'd0, c_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_add("t1", 8'h0f, 8'h01, 1'b0, 8'h10, 1'b0);
        run_add("t2", 8'hff, 8'h01, 1'b0, 8'h00, 1'b1);
        run_add("t3a", 8'hff, 8'hff, 1'b1, 8'hff, 1'b1);
        run_add("t3b", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // Result stalled in DONE while the next operand waits.
        ready_ctl = 1'b0;
        start_add(8'h12, 8'h34, 1'b1, lat, ok);
        check_val("t4_lat", lat, 32'd8);
        check_val("t4_sum", {24'd0, sum}, 32'h47);
        in_valid = 1'b1;
        a        = 8'h55;
        b        = 8'h00;
        c_in     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            check_val("t4_hold_sum", {24'd0, sum}, 32'h47);
            check_val("t4_hold_cout", {31'd0, c_out}, 32'd0);
            check_val("t4_hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        ready_ctl = 1'b1;
        @(negedge clk);
        check_val("t4_idle_rdy", {31'd0, in_ready}, 32'd1);
        check_val("t4_idle_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'h00;
        @(negedge clk);
        check_val("t4_busy", {31'd0, busy}, 32'd1);
        lat = 0;
        ok  = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("t4_reload_ok", {31'd0, ok}, 32'd1);
        check_val("t4_reload_lat", lat, 32'd8);
        check_val("t4_reload_sum", {24'd0, sum}, 32'h55);
        @(negedge clk);

        // Asynchronous reset mid-operation.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = 8'h03;
        b        = 8'h04;
        c_in     = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("t5_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("t5_valid", {31'd0, out_valid}, 32'd0);
        check_val("t5_sum", {24'd0, sum}, 32'd0);
        check_val("t5_rdy", {31'd0, in_ready}, 32'd1);
        check_val("t5_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_val("t5_no_result", {31'd0, seen}, 32'd0);

        // Randomized traffic with result-side stalls.
        rand_mode = 1'b1;
        mon_en    = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            a        = 8'($urandom);
            b        = 8'($urandom);
            c_in     = 1'($urandom_range(0, 1));
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                check_val("rand_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check_val("rand_accepted", n_acc, 32'd1000);
        check_val("rand_received", n_got, 32'd1000);
        check_val("rand_pending", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
